axi_config_init: RTL

AXI_CONFIG_INIT -- requirements
Module: axi_config_init

---
 rtl/axi_config_pkg.sv | 22 ++
 rtl/axi_config_init.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_config_pkg.sv
// Shared AXI constants and the sequencer state type for axi_config_init.
package axi_config_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_READ  = 3'd4,
    ST_RDATA = 3'd5
  } state_t;

endpackage

// File: rtl/axi_config_init.sv
// axi_config_init: walks an externally supplied table of (addr, data, strb)
// entries and issues one single-beat AXI4 write per entry, stopping on the
// first non-OKAY response. Defining AXI_CONFIG_INIT_VERIFY_EN adds a
// read-back of every entry, compared under its byte strobes.
//
// Handshake: every channel transfers on a cycle where valid && ready are both
// high at the rising clock edge; a raised valid and its payload are held
// unchanged until that transfer, and valid never depends on ready.
module axi_config_init
  import axi_config_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_WIDTH   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_WIDTH-1:0]  err_idx,
  output logic [IDX_WIDTH-1:0]  tbl_idx,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  input  logic [STRB_WIDTH-1:0] tbl_strb,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output state_t                dbg_state_o
);

  localparam logic [2:0]           AXI_SIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

  state_t                state_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  err_idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;

`ifdef AXI_CONFIG_INIT_VERIFY_EN
  logic arvalid_q;
  logic rready_q;

  // Expand write strobes into a bit mask over the data bus.
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [STRB_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_WIDTH; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction
`endif

  // Sequencer: one pass over the table, one write (plus optional read) per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef AXI_CONFIG_INIT_VERIFY_EN
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q     <= '0;
            err_idx_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          addr_q    <= tbl_addr;
          data_q    <= tbl_data;
          strb_q    <= tbl_strb;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          // AW and W retire independently; leave once neither is outstanding.
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) begin
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
`ifdef AXI_CONFIG_INIT_VERIFY_EN
              arvalid_q <= 1'b1;
              state_q   <= ST_READ;
`else
              if (idx_q == LAST_IDX) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                idx_q   <= idx_q + IDX_WIDTH'(1);
                state_q <= ST_LOAD;
              end
`endif
            end
          end
        end
`ifdef AXI_CONFIG_INIT_VERIFY_EN
        ST_READ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            rready_q <= 1'b0;
            if ((m_axi_rresp != AXI_RESP_OKAY) ||
                (((m_axi_rdata ^ data_q) & byte_mask(strb_q)) != '0)) begin
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end else if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + IDX_WIDTH'(1);
              state_q <= ST_LOAD;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_idx     = err_idx_q;
  assign tbl_idx     = idx_q;
  assign dbg_state_o = state_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

`ifdef AXI_CONFIG_INIT_VERIFY_EN
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};
`else
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd0;
  assign m_axi_arburst = 2'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

  // Read channel and response IDs have no consumer without read-back.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_arready,
                           m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

endmodule
